// File: rtl/sap1_ctrl.sv
// sap1_ctrl - microsequencer for the 8-bit SAP-style datapath.
//
// Runs the fetch/decode/execute T-state sequence and drives one-hot control
// strobes for PC, MAR, RAM, IR, A/B registers, output register and ALU.
// The ALU result is registered inside the ALU, so after a sum/sub strobe the
// sequencer parks in WAIT for ALU_LAT cycles before capturing it in T7.
//
// Optional build macro: SAP1_CTRL_JUMP_EN adds JMP (0x6), JC (0x7) and JZ (0x8).
// Without it those opcodes behave as NOPs, pc_load stays 0 and carry/zero are
// ignored.
//
// Parameters:
//   OP_W     opcode width (IR upper nibble)
//   ALU_LAT  cycles from sum/sub strobe to valid ALU output (0 allowed)
//
// Ports:
//   clk                    system clock, rising edge
//   rst                    asynchronous reset, active-low
//   run                    1 = execute, 0 = stop at next instruction boundary
//   opcode                 IR[7:4], captured on entry to T4
//   carry, zero            ALU flags, captured on entry to T4 (jump build only)
//   pc_out/pc_inc/pc_load  PC drive bus / increment / load from bus
//   mar_load               MAR load from bus
//   ram_out                RAM drive bus
//   ir_load/ir_out         IR load / IR low nibble drive bus
//   a_load/a_out           accumulator load / drive bus
//   b_load                 B register load
//   sum/sub/fi             ALU add, subtract, flag-latch enable
//   alu_out                ALU result drive bus
//   out_load               output register load
//   halted                 HLT executed (sticky until reset)
//
// state | meaning
// IDLE  | stopped, waiting for run
// T1    | PC -> MAR
// T2    | PC increment
// T3    | RAM -> IR
// T4    | decode / first execute step
// T5    | memory operand -> A (LDA) or B (ADD/SUB)
// T6    | ALU sum/sub strobe
// WAIT  | ALU latency hold
// T7    | ALU result -> A, latch flags
// HALT  | HLT executed, sticky

module sap1_ctrl #(
  parameter int OP_W    = 4,
  parameter int ALU_LAT = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  input  logic [OP_W-1:0] opcode,
  input  logic            carry,
  input  logic            zero,
  output logic            pc_out,
  output logic            pc_inc,
  output logic            pc_load,
  output logic            mar_load,
  output logic            ram_out,
  output logic            ir_load,
  output logic            ir_out,
  output logic            a_load,
  output logic            a_out,
  output logic            b_load,
  output logic            sum,
  output logic            sub,
  output logic            fi,
  output logic            alu_out,
  output logic            out_load,
  output logic            halted
);

  localparam int CNT_W = (ALU_LAT > 0) ? $clog2(ALU_LAT + 1) : 1;
  localparam logic [CNT_W-1:0] LAT_M1 = (ALU_LAT > 0) ? CNT_W'(ALU_LAT - 1) : '0;

  localparam logic [OP_W-1:0] OP_LDA = OP_W'(4'h0);
  localparam logic [OP_W-1:0] OP_ADD = OP_W'(4'h1);
  localparam logic [OP_W-1:0] OP_SUB = OP_W'(4'h2);
  localparam logic [OP_W-1:0] OP_OUT = OP_W'(4'hE);
  localparam logic [OP_W-1:0] OP_HLT = OP_W'(4'hF);

  typedef enum logic [3:0] {
    S_IDLE, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_WAIT, S_T7, S_HALT
  } state_t;

  state_t            r_state;
  state_t            w_next;
  state_t            w_eoi;
  logic [OP_W-1:0]   r_op;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_is_alu;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // The opcode is held in a local register so that T4..T7 strobes depend
  // only on registered state, never on the live IR bus.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                  r_op <= '0;
    else if (r_state == S_T3)  r_op <= opcode;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                      r_cnt <= '0;
    else if (r_state == S_T6)                      r_cnt <= LAT_M1;
    else if (r_state == S_WAIT && r_cnt != '0)     r_cnt <= r_cnt - CNT_W'(1);
  end

`ifdef SAP1_CTRL_JUMP_EN
  localparam logic [OP_W-1:0] OP_JMP = OP_W'(4'h6);
  localparam logic [OP_W-1:0] OP_JC  = OP_W'(4'h7);
  localparam logic [OP_W-1:0] OP_JZ  = OP_W'(4'h8);

  // Taken/not-taken is resolved with the flags present on entry to T4 so
  // the T4 strobes remain a pure function of registered state.
  logic r_jtake;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_jtake <= 1'b0;
    else if (r_state == S_T3)
      r_jtake <= (opcode == OP_JMP) || (opcode == OP_JC && carry) ||
                 (opcode == OP_JZ && zero);
  end
`else
  logic w_unused_flags;
  assign w_unused_flags = carry ^ zero;
`endif

  assign w_is_alu = (r_op == OP_ADD) || (r_op == OP_SUB);
  assign w_eoi    = run ? S_T1 : S_IDLE;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (run) w_next = S_T1;
      S_T1:   w_next = S_T2;
      S_T2:   w_next = S_T3;
      S_T3:   w_next = S_T4;
      S_T4: begin
        if (w_is_alu || r_op == OP_LDA) w_next = S_T5;
        else if (r_op == OP_HLT)        w_next = S_HALT;
        else                            w_next = w_eoi;
      end
      S_T5:   w_next = w_is_alu ? S_T6 : w_eoi;
      S_T6:   w_next = (ALU_LAT == 0) ? S_T7 : S_WAIT;
      S_WAIT: if (r_cnt == '0) w_next = S_T7;
      S_T7:   w_next = w_eoi;
      S_HALT: w_next = S_HALT;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    pc_out   = 1'b0;
    pc_inc   = 1'b0;
    pc_load  = 1'b0;
    mar_load = 1'b0;
    ram_out  = 1'b0;
    ir_load  = 1'b0;
    ir_out   = 1'b0;
    a_load   = 1'b0;
    a_out    = 1'b0;
    b_load   = 1'b0;
    sum      = 1'b0;
    sub      = 1'b0;
    fi       = 1'b0;
    alu_out  = 1'b0;
    out_load = 1'b0;
    halted   = 1'b0;
    case (r_state)
      S_T1: begin
        pc_out   = 1'b1;
        mar_load = 1'b1;
      end
      S_T2: pc_inc = 1'b1;
      S_T3: begin
        ram_out = 1'b1;
        ir_load = 1'b1;
      end
      S_T4: begin
        if (w_is_alu || r_op == OP_LDA) begin
          ir_out   = 1'b1;
          mar_load = 1'b1;
        end else if (r_op == OP_OUT) begin
          a_out    = 1'b1;
          out_load = 1'b1;
        end
`ifdef SAP1_CTRL_JUMP_EN
        else if (r_jtake) begin
          ir_out  = 1'b1;
          pc_load = 1'b1;
        end
`endif
      end
      S_T5: begin
        ram_out = 1'b1;
        a_load  = (r_op == OP_LDA);
        b_load  = w_is_alu;
      end
      S_T6: begin
        sum = (r_op == OP_ADD);
        sub = (r_op == OP_SUB);
      end
      S_T7: begin
        alu_out = 1'b1;
        a_load  = 1'b1;
        fi      = 1'b1;
      end
      S_HALT: halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: doc/sap1_ctrl.md
Name: sap1_ctrl

Overview:
- Microsequencer for the 8-bit SAP-style datapath. Runs the fetch/decode/execute T-state sequence and drives one-hot control strobes for the PC, MAR, RAM, IR, A/B registers, output register and ALU (sum/sub/fi).
- Absorbs the ALU's registered result latency with a programmable wait counter, so the ALU result is captured only when valid.

Parameters:
- OP_W, 4, opcode width (IR upper nibble).
- ALU_LAT, 2, clock cycles from a sum/sub strobe until the ALU output is valid; 0 allowed.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-low
- run  in  1  level; 1 = execute instructions, 0 = stop at next instruction boundary
- opcode  in  OP_W  IR[7:4], sampled in T4 only
- carry  in  1  ALU carry flag (used only with JUMP_EN)
- zero  in  1  ALU zero flag (used only with JUMP_EN)
- pc_out, pc_inc, pc_load  out  1 each  PC drive bus / increment / load from bus
- mar_load  out  1  MAR load from bus
- ram_out  out  1  RAM drive bus
- ir_load, ir_out  out  1 each  IR load / IR low nibble drive bus
- a_load, a_out  out  1 each  accumulator load / drive bus
- b_load  out  1  B register load
- sum, sub, fi  out  1 each  ALU add strobe, subtract strobe, flag-latch enable
- alu_out  out  1  ALU result drive bus
- out_load  out  1  output register load
- halted  out  1  HLT executed

Behaviour:
- Moore machine. Every strobe decodes from the state register only; there is no combinational input-to-output path. At most one bus driver is active per state.
- Reset (rst=0, async): state=IDLE, wait counter=0, all outputs 0. Reset mid-instruction aborts immediately; no partial strobes remain.
- IDLE: all strobes 0. Go to T1 when run=1.
- Fetch:
  - T1: pc_out, mar_load.
  - T2: pc_inc.
  - T3: ram_out, ir_load. Go to T4.
- Opcodes: LDA=0x0, ADD=0x1, SUB=0x2, OUT=0xE, HLT=0xF. Opcode is sampled once, on entry to T4, into an internal register.
- LDA: T4 ir_out+mar_load; T5 ram_out+a_load.
- ADD/SUB:
  - T4 ir_out+mar_load.
  - T5 ram_out+b_load.
  - T6: sum (ADD) or sub (SUB), exactly one cycle. sum and sub are never both 1.
  - WAIT: holds ALU_LAT cycles with all strobes 0. Counter loads ALU_LAT-1 on leaving T6 and decrements to 0. WAIT is skipped when ALU_LAT=0.
  - T7: alu_out+a_load+fi, one cycle.
- OUT: T4 a_out+out_load.
- HLT: T4 goes to HALT. HALT is sticky: halted=1, all strobes 0, run ignored; exit only via reset.
- Undefined opcodes (and jump opcodes without JUMP_EN): NOP, T4 with no strobes.
- End of instruction (last exec state) goes to T1 if run=1, else to IDLE. A run drop mid-instruction never truncates the instruction.
- Instruction length in cycles: LDA 5, ADD/SUB 7+ALU_LAT, OUT 4, NOP 4, HLT 4 then HALT.
- Wait counter width is clog2(ALU_LAT+1), minimum 1. No wrap: it decrements only in WAIT.

Optional Feature:
- SAP1_CTRL_JUMP_EN defined: adds JMP=0x6, JC=0x7, JZ=0x8.
  - T4 asserts ir_out+pc_load when the jump is taken: JMP always, JC if carry=1, JZ if zero=1. carry and zero are sampled in T4.
  - Not-taken jumps run T4 with no strobes.
  - All jumps are 4 cycles.
- Not defined: 0x6/0x7/0x8 are NOPs, pc_load is tied 0, and carry/zero are unused.

Test Plan:
- Reset/idle: rst low mid-T6, then high with run=0 -> all outputs 0, state IDLE for 10 cycles; raise run -> pc_out+mar_load on the next cycle.
- LDA then OUT, run=1 -> strobe sequence T1..T5 then T1..T4, exactly 9 cycles; out_load pulses once in cycle 9.
- ADD with ALU_LAT=2 -> sum high 1 cycle in T6, 2 idle cycles, then alu_out+a_load+fi in cycle 9. Repeat with SUB (sub only) and with ALU_LAT=0 (7 cycles, no idle).
- HLT -> halted=1 from cycle 5 onward; toggling run for 20 cycles leaves all strobes 0; rst clears halted.
- run dropped in T5 of ADD -> the instruction completes through T7, then IDLE; no T1 strobes.
- JUMP_EN: JC with carry=1 -> pc_load+ir_out in T4; carry=0 -> no pc_load. Without the macro, opcode 0x6 -> pc_load never asserted, 4-cycle NOP.
